snake_update_scheduler: RTL and testbench

//  Sequences one snake-move update per game_tik pulse from the game-delay FSM.

---
 rtl/snake_update_scheduler_if.sv | 54 +++++
 rtl/snake_update_scheduler.sv | 127 ++++++++++++
 tb/tb_snake_update_scheduler.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/snake_update_scheduler_if.sv
// snake_update_scheduler_if
//  Handshake/result bundle between the snake move scheduler and its
//  neighbours. The tick generator, buttons and the collision datapath drive it.
//  The segment-memory strobes and the game status flow back over it.
//  Modports:
//   master : drives start, game_tik, btn_*, collision_hit, fruit_hit;
//            observes everything else
//   slave  : the scheduler itself
//  Optional: SCHED_OVERRUN_EN adds the sticky 'overrun' flag.
interface snake_update_scheduler_if #(
  parameter int LEN_W = 7
);
  logic             start;
  logic             game_tik;
  logic             btn_up;
  logic             btn_down;
  logic             btn_left;
  logic             btn_right;
  logic             collision_hit;
  logic             fruit_hit;
  logic [1:0]       cur_dir;
  logic             head_calc_en;
  logic             shift_en;
  logic [LEN_W-1:0] shift_idx;
  logic             head_wr_en;
  logic [LEN_W-1:0] snake_length;
  logic             fruit_eaten;
  logic             update_done;
  logic             busy;
  logic             game_over;
`ifdef SCHED_OVERRUN_EN
  logic             overrun;
`endif

  modport master (
    output start, game_tik, btn_up, btn_down, btn_left, btn_right,
           collision_hit, fruit_hit,
`ifdef SCHED_OVERRUN_EN
    input  overrun,
`endif
    input  cur_dir, head_calc_en, shift_en, shift_idx, head_wr_en,
           snake_length, fruit_eaten, update_done, busy, game_over
  );

  modport slave (
    input  start, game_tik, btn_up, btn_down, btn_left, btn_right,
           collision_hit, fruit_hit,
`ifdef SCHED_OVERRUN_EN
    output overrun,
`endif
    output cur_dir, head_calc_en, shift_en, shift_idx, head_wr_en,
           snake_length, fruit_eaten, update_done, busy, game_over
  );
endinterface

// File: rtl/snake_update_scheduler.sv
// snake_update_scheduler
//  Runs one snake-move update per game_tik. The update does the following:
//  it latches the direction, strobes the head calculation, and samples the
//  collision and fruit results. It then walks the body shift from the tail
//  down to segment 1, writes the new head, and tracks length and game-over.
//  Ports:
//   clock_25  in  system clock
//   reset     in  asynchronous active-low reset
//   bus       slave modport of snake_update_scheduler_if (start, game_tik,
//             buttons, hit results in; direction, strobes, length, status out)
//  Optional feature: define SCHED_OVERRUN_EN to add the sticky bus.overrun
//  flag. It is set by a tik that arrives while busy.
//  Every output is a flop, loaded from the next-state decode, so all outputs
//  line up exactly with the state they describe.
module snake_update_scheduler #(
  parameter int MAX_LEN  = 64,
  parameter int LEN_W    = 7,
  parameter int INIT_LEN = 3
) (
  input  logic                     clock_25,
  input  logic                     reset,
  snake_update_scheduler_if.slave  bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT, S_LATCH, S_HCALC, S_CHECK, S_SHIFT, S_HWR, S_DONE, S_OVER
  } state_t;

  state_t           r_state, w_nxt;
  logic [1:0]       r_dir, r_pend;
  logic [LEN_W-1:0] r_len, r_idx;
  logic             r_hcalc, r_shift, r_hwr, r_fruit, r_done, r_busy, r_over;
  logic             w_start_run, w_check_ok, w_grow;

  always_ff @(posedge clock_25 or negedge reset)
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_nxt;

  // Dropping start aborts from any state, including mid-shift.
  always_comb begin
    w_nxt = S_IDLE;
    if (bus.start) begin
      case (r_state)
        S_IDLE:  w_nxt = S_WAIT;
        S_WAIT:  w_nxt = bus.game_tik ? S_LATCH : S_WAIT;
        S_LATCH: w_nxt = S_HCALC;
        S_HCALC: w_nxt = S_CHECK;
        S_CHECK: w_nxt = bus.collision_hit ? S_OVER : S_SHIFT;
        // <= 1 rather than == 1 so a corrupted index cannot stall the shift
        S_SHIFT: w_nxt = (r_idx <= LEN_W'(1)) ? S_HWR : S_SHIFT;
        S_HWR:   w_nxt = S_DONE;
        S_DONE:  w_nxt = S_WAIT;
        S_OVER:  w_nxt = S_OVER;
        default: w_nxt = S_IDLE;
      endcase
    end
  end

  assign w_start_run = (r_state == S_IDLE)  && (w_nxt == S_WAIT);
  assign w_check_ok  = (r_state == S_CHECK) && (w_nxt == S_SHIFT);
  assign w_grow      = w_check_ok && bus.fruit_hit && (r_len < LEN_W'(MAX_LEN));

  // LATCH commits the pending value held before this cycle. A button in the
  // same cycle only updates pending and waits for the next tik.
  always_ff @(posedge clock_25 or negedge reset)
    if (!reset) begin
      r_pend <= 2'b00;
      r_dir  <= 2'b00;
      r_len  <= LEN_W'(INIT_LEN);
      r_idx  <= '0;
    end else begin
      if (w_start_run)           r_pend <= 2'b00;
      else if (bus.btn_up)       r_pend <= 2'b01;
      else if (bus.btn_down)     r_pend <= 2'b11;
      else if (bus.btn_left)     r_pend <= 2'b10;
      else if (bus.btn_right)    r_pend <= 2'b00;

      if (w_start_run)           r_dir <= 2'b00;
      else if (r_state == S_LATCH && r_pend != (r_dir ^ 2'b10))
                                 r_dir <= r_pend;

      if (w_start_run)           r_len <= LEN_W'(INIT_LEN);
      else if (w_grow)           r_len <= r_len + LEN_W'(1);

      // Growth starts from the old length, which is the new tail slot.
      if (w_check_ok)            r_idx <= w_grow ? r_len : r_len - LEN_W'(1);
      else if (r_state == S_SHIFT && w_nxt == S_SHIFT)
                                 r_idx <= r_idx - LEN_W'(1);
      else                       r_idx <= '0;
    end

  always_ff @(posedge clock_25 or negedge reset)
    if (!reset) begin
      r_hcalc <= 1'b0; r_shift <= 1'b0; r_hwr  <= 1'b0; r_fruit <= 1'b0;
      r_done  <= 1'b0; r_busy  <= 1'b0; r_over <= 1'b0;
    end else begin
      r_hcalc <= (w_nxt == S_HCALC);
      r_shift <= (w_nxt == S_SHIFT);
      r_hwr   <= (w_nxt == S_HWR);
      r_done  <= (w_nxt == S_DONE);
      r_over  <= (w_nxt == S_OVER);
      // fruit_eaten pulses even at full length, where no growth happens
      r_fruit <= w_check_ok && bus.fruit_hit;
      r_busy  <= (w_nxt inside {S_LATCH, S_HCALC, S_CHECK, S_SHIFT, S_HWR, S_DONE});
    end

`ifdef SCHED_OVERRUN_EN
  logic r_overrun;
  always_ff @(posedge clock_25 or negedge reset)
    if (!reset)                        r_overrun <= 1'b0;
    else if (w_start_run)              r_overrun <= 1'b0;
    else if (bus.game_tik && r_busy)   r_overrun <= 1'b1;
  assign bus.overrun = r_overrun;
`endif

  assign bus.cur_dir      = r_dir;
  assign bus.head_calc_en = r_hcalc;
  assign bus.shift_en     = r_shift;
  assign bus.shift_idx    = r_idx;
  assign bus.head_wr_en   = r_hwr;
  assign bus.snake_length = r_len;
  assign bus.fruit_eaten  = r_fruit;
  assign bus.update_done  = r_done;
  assign bus.busy         = r_busy;
  assign bus.game_over    = r_over;

endmodule

// File: tb/tb_snake_update_scheduler.sv
// tb_snake_update_scheduler
//  Directed bench for snake_update_scheduler. It uses MAX_LEN=6 so that the
//  full-length case is reached quickly. Inputs change 1 ns after the rising
//  edge, and outputs are sampled at the same point.
module tb_snake_update_scheduler;
  localparam int MAX_LEN = 6, LEN_W = 7, INIT_LEN = 3;

  logic clock_25 = 1'b0;
  logic reset    = 1'b0;
  int   n_chk = 0, n_err = 0;

  snake_update_scheduler_if #(.LEN_W(LEN_W)) bus();

  snake_update_scheduler #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .INIT_LEN(INIT_LEN))
    dut (.clock_25(clock_25), .reset(reset), .bus(bus));

  always #20 clock_25 = ~clock_25;

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock_25); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic set_btn(input logic [3:0] b); // {up,down,left,right}
    {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = b;
  endtask

  // One update from WAIT_TIK. The tik is in cycle T. btl is a button pressed in
  // the LATCH cycle. xt is an extra tik during T+2. shifts and len are the
  // hand-computed expected values.
  task automatic upd(input logic fr, input logic co, input logic xt,
                     input logic [3:0] btl, input int shifts, input logic [LEN_W-1:0] len);
    bus.game_tik = 1'b1; tick(); bus.game_tik = 1'b0;           // T+1 LATCH
    chk("latch_busy", bus.busy, 1);
    chk("latch_hcalc", bus.head_calc_en, 0);
    set_btn(btl); tick(); set_btn(4'b0);                        // T+2
    chk("hcalc_en", bus.head_calc_en, 1);
    bus.game_tik = xt; tick(); bus.game_tik = 1'b0;             // T+3 CHECK
    chk("check_hcalc", bus.head_calc_en, 0);
    chk("check_shift", bus.shift_en, 0);
    bus.fruit_hit = fr; bus.collision_hit = co;
    tick(); bus.fruit_hit = 1'b0; bus.collision_hit = 1'b0;     // T+4
    if (co) begin
      chk("over_flag", bus.game_over, 1);
      chk("over_shift", bus.shift_en, 0);
      chk("over_fruit", bus.fruit_eaten, 0);
      chk("over_busy", bus.busy, 0);
      chk("over_len", bus.snake_length, len);
    end else begin
      chk("fruit_eaten", bus.fruit_eaten, fr);
      for (int i = 0; i < shifts; i++) begin
        chk("shift_en", bus.shift_en, 1);
        chk("shift_idx", bus.shift_idx, shifts - i);
        tick();
      end
      chk("end_shift", bus.shift_en, 0);
      chk("head_wr", bus.head_wr_en, 1);
      tick();
      chk("done", bus.update_done, 1);
      chk("done_busy", bus.busy, 1);
      tick();
      chk("done_drop", bus.update_done, 0);
      chk("idle_busy", bus.busy, 0);
      chk("length", bus.snake_length, len);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.game_tik = 1'b0; set_btn(4'b0);
    bus.fruit_hit = 1'b0; bus.collision_hit = 1'b0;
    tick(); tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_over", bus.game_over, 0);
    chk("rst_dir", bus.cur_dir, 0);
    chk("rst_len", bus.snake_length, INIT_LEN);
    chk("rst_idx", bus.shift_idx, 0);
    chk("rst_strb", {bus.head_calc_en, bus.shift_en, bus.head_wr_en,
                     bus.fruit_eaten, bus.update_done}, 0);
    reset = 1'b1; tick();

    // A tik in IDLE is ignored.
    bus.game_tik = 1'b1; tick(); bus.game_tik = 1'b0; tick();
    chk("idle_tik", bus.busy, 0);

    bus.start = 1'b1; tick();                                   // WAIT_TIK
    chk("wait_busy", bus.busy, 0);

    upd(0, 0, 0, 4'b0, 2, 3);                                   // plain move
    upd(1, 0, 0, 4'b0, 3, 4);                                   // fruit: grow to 4

    set_btn(4'b0010); tick(); set_btn(4'b0);                    // left = reversal
    upd(0, 0, 0, 4'b0, 3, 4);
    chk("dir_rev", bus.cur_dir, 2'b00);
    set_btn(4'b1000); tick(); set_btn(4'b0);                    // up
    upd(0, 0, 0, 4'b0, 3, 4);
    chk("dir_up", bus.cur_dir, 2'b01);

    // Left and right together: left wins. Down in the LATCH cycle waits.
    set_btn(4'b0011); tick(); set_btn(4'b0);
    upd(0, 0, 0, 4'b0100, 3, 4);
    chk("dir_left", bus.cur_dir, 2'b10);
    upd(0, 0, 1, 4'b0, 3, 4);                                   // extra tik dropped
    chk("dir_down", bus.cur_dir, 2'b11);
`ifdef SCHED_OVERRUN_EN
    chk("overrun_set", bus.overrun, 1);
`endif

    upd(1, 0, 0, 4'b0, 4, 5);
    upd(1, 0, 0, 4'b0, 5, 6);
    upd(1, 0, 0, 4'b0, 5, 6);                                   // at MAX_LEN

    upd(1, 1, 0, 4'b0, 0, 6);                                   // collision wins
    bus.game_tik = 1'b1; tick(); tick(); bus.game_tik = 1'b0;
    chk("over_hold", bus.game_over, 1);
    chk("over_nobusy", bus.busy, 0);
    bus.start = 1'b0; tick();
    chk("over_exit", bus.game_over, 0);
    bus.start = 1'b1; tick();
    chk("restart_len", bus.snake_length, INIT_LEN);
    chk("restart_dir", bus.cur_dir, 0);
`ifdef SCHED_OVERRUN_EN
    chk("overrun_clr", bus.overrun, 0);
`endif

    // Abort in the middle of the shift.
    bus.game_tik = 1'b1; tick(); bus.game_tik = 1'b0;           // T+1
    tick(); tick(); tick();                                     // T+4
    chk("abort_pre", bus.shift_en, 1);
    bus.start = 1'b0; tick();
    chk("abort_shift", bus.shift_en, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_hwr", bus.head_wr_en, 0);
    tick();
    chk("abort_done", bus.update_done, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
